boot_loader: RTL
================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ROM_SIZE, default 8: instruction-memory address width in bits; SHALL be >= 8.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high; sampled only on the rising clk edge.
REQ-004 start  input  1  one-cycle pulse; restarts a load from DONE or ERR.
REQ-005 in_valid  input  1  host byte valid.
REQ-006 in_byte  input  8  host byte.
REQ-007 in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready.
REQ-008 rom_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 rom_waddr  output  ROM_SIZE  write word address.
REQ-010 rom_wdata  output  16  write word.
REQ-011 cpu_rst  output  1  held high to keep the processor in reset while no valid image is loaded.
REQ-012 done  output  1  image loaded and checksum correct.
REQ-013 err  output  1  load aborted (bad count or checksum mismatch).
REQ-014 word_cnt  output  8  number of words written in the current load.

Function
REQ-015 Frame format, in order: sync 0xA5; count N (words, 1..255); N words, each sent as high byte then low byte; checksum byte equal to the XOR of all 2N data bytes.
REQ-016 States: IDLE, COUNT, HI, LO, CHECK, DONE, ERR.
REQ-017 in_ready SHALL be 1 in IDLE, COUNT, HI, LO and CHECK, and 0 in DONE and ERR.
REQ-018 IDLE: an accepted 0xA5 SHALL go to COUNT; any other accepted byte SHALL be discarded, with the FSM staying in IDLE.
REQ-019 COUNT: an accepted N=0 SHALL go to ERR; an accepted N>0 SHALL be latched, clear word_cnt and the checksum accumulator, and go to HI.
REQ-020 HI: an accepted byte SHALL be latched as the high byte and XORed into the checksum; the FSM SHALL go to LO.
REQ-021 LO: an accepted byte SHALL be XORed into the checksum; in the next cycle rom_we SHALL be 1 for exactly one cycle with rom_waddr=word_cnt (zero-extended) and rom_wdata={high,low}, and word_cnt SHALL increment in that same cycle.
REQ-022 LO exit: if this was word N, the FSM SHALL go to CHECK; otherwise it SHALL go to HI.
REQ-023 Write latency SHALL be one cycle from acceptance of the low byte; consecutive words at full rate SHALL produce rom_we pulses two cycles apart.
REQ-024 CHECK: an accepted byte equal to the accumulated XOR SHALL go to DONE; a mismatch SHALL go to ERR.
REQ-025 DONE SHALL set done=1 and cpu_rst=0, and hold until start or rst.
REQ-026 ERR SHALL set err=1 and cpu_rst=1, and hold until start or rst; words already written are considered invalid.
REQ-027 start in DONE or ERR SHALL clear done and err, set cpu_rst=1, and go to IDLE on the next edge.
REQ-028 start SHALL be ignored in all other states.
REQ-029 When start and an accepted byte coincide, start SHALL be ignored and the byte processed.
REQ-030 cpu_rst SHALL be 1 in every state except DONE.
REQ-031 in_valid=0 SHALL stall the FSM in its current state with no side effects.
REQ-032 rom_waddr and rom_wdata SHALL hold their last values whenever rom_we=0.

Reset
REQ-033 When rst=1, the block SHALL enter IDLE with in_ready=1, rom_we=0, rom_waddr=0, rom_wdata=0, cpu_rst=1, done=0, err=0, word_cnt=0, and the checksum cleared.
REQ-034 rst asserted mid-load SHALL abort the load immediately without generating any further rom_we pulse, including a write pending from a low byte accepted in the same cycle.
REQ-035 rst SHALL take priority over start and over byte acceptance.

Verification
REQ-036 Stream 0xA5,0x02,0x12,0x34,0xAB,0xCD, then checksum 0x12^0x34^0xAB^0xCD=0x40 -> two writes, (addr0,0x1234) and (addr1,0xABCD); then done=1, cpu_rst=0, word_cnt=2.
REQ-037 Same stream with checksum 0x41 -> both writes occur; then err=1, cpu_rst=1, done=0, in_ready=0.
REQ-038 Bytes 0x00,0xFF, then 0xA5,0x01,0xDE,0xAD,0x73 -> leading bytes discarded; single write (addr0,0xDEAD); done=1.
REQ-039 0xA5,0x00 -> err=1, with no rom_we pulse; then start -> IDLE, err=0, in_ready=1.
REQ-040 rst pulsed in the same cycle a low byte is accepted -> no rom_we pulse; all outputs at reset values.
REQ-041 Valid load with in_valid toggling 1/0 on every cycle -> identical writes and final state to REQ-036, with each rom_we exactly one cycle wide.

Source files
------------

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed host byte stream to instruction-memory image loader
// Frame: 0xA5, N words (1..255), N big-endian 16-bit words, XOR checksum of data bytes.
module boot_loader #(
  parameter int ROM_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_byte,
  output logic                in_ready,
  output logic                rom_we,
  output logic [ROM_SIZE-1:0] rom_waddr,
  output logic [15:0]         rom_wdata,
  output logic                cpu_rst,
  output logic                done,
  output logic                err,
  output logic [7:0]          word_cnt
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state, state_nx;
  logic [7:0] n_words;
  logic [7:0] csum;
  logic [7:0] hi_byte;
  logic       accept;
  logic       last_word;

  // Only the two terminal states refuse bytes; everything else always accepts.
  assign in_ready  = (state != S_DONE) && (state != S_ERR);
  assign accept    = in_valid && in_ready;
  assign last_word = (word_cnt == n_words - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    err      = 1'b0;
    cpu_rst  = 1'b1;
    case (state)
      S_IDLE: begin
        if (in_valid && in_byte == SYNC_BYTE) state_nx = S_COUNT;
      end
      S_COUNT: begin
        if (in_valid) state_nx = (in_byte == 8'd0) ? S_ERR : S_HI;
      end
      S_HI: begin
        if (in_valid) state_nx = S_LO;
      end
      S_LO: begin
        if (in_valid) state_nx = last_word ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        if (in_valid) state_nx = (in_byte == csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) state_nx = S_IDLE;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The write is registered at the low-byte edge, so word_cnt already shows
  // the incremented count during the rom_we cycle while rom_waddr holds the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= 16'd0;
      word_cnt  <= 8'd0;
      n_words   <= 8'd0;
      csum      <= 8'd0;
      hi_byte   <= 8'd0;
    end else begin
      rom_we <= 1'b0;
      if (accept) begin
        case (state)
          S_COUNT: begin
            if (in_byte != 8'd0) begin
              n_words  <= in_byte;
              word_cnt <= 8'd0;
              csum     <= 8'd0;
            end
          end
          S_HI: begin
            hi_byte <= in_byte;
            csum    <= csum ^ in_byte;
          end
          S_LO: begin
            csum      <= csum ^ in_byte;
            rom_we    <= 1'b1;
            rom_waddr <= ROM_SIZE'(word_cnt);
            rom_wdata <= {hi_byte, in_byte};
            word_cnt  <= word_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
